// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared execution-stage types: unit codes, instruction formats
//
// Purpose: constants and enums shared by decode and the execution stage.
// Ports: none (package).

package exec_pkg;

    localparam int UNIT_CODE_W = 3;

    // Functional unit codes as used by decode when steering instructions.
    typedef enum logic [UNIT_CODE_W-1:0] {
        UNIT_FX     = 3'd0,
        UNIT_FP     = 3'd1,
        UNIT_LDST   = 3'd2,
        UNIT_BRANCH = 3'd3,
        UNIT_TRAP   = 3'd4
    } unit_code_e;

    // Instruction encoding formats carried inside the opaque payload.
    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } instr_fmt_e;

    // A unit code is legal only if a unit with that index is attached.
    function automatic logic unit_code_legal(input int code, input int num_units);
        return code < num_units;
    endfunction

endpackage

// File: rtl/exec_dispatch_unit_rr_arbiter.sv
// rtl/exec_dispatch_unit_rr_arbiter.sv - round-robin one-hot arbiter
//
// Purpose: grants the first request at or after the rotating pointer; the
//   pointer moves to one past the winner whenever a grant is made and holds
//   otherwise.
// Ports:
//   clk          in   clock
//   rst          in   synchronous active-high reset (pointer -> 0)
//   request      in   N    request vector
//   grant        out  N    one-hot grant (combinational)
//   grant_idx    out  IDX_W index of the granted requester
//   grant_valid  out  1    any grant this cycle

module rr_arbiter #(
    parameter int N     = 5,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     request,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    logic [IDX_W-1:0] ptr_q;

    // Two passes: the first looks only at requesters at or above the pointer,
    // the second (wrap-around) takes the lowest requester overall.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!grant_valid && request[j] && (j >= int'(ptr_q))) begin
                grant_valid = 1'b1;
                grant[j]    = 1'b1;
                grant_idx   = IDX_W'(j);
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!grant_valid && request[j]) begin
                grant_valid = 1'b1;
                grant[j]    = 1'b1;
                grant_idx   = IDX_W'(j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (grant_valid) begin
            if (int'(grant_idx) == N - 1) begin
                ptr_q <= '0;
            end else begin
                ptr_q <= grant_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/exec_dispatch_unit.sv
// rtl/exec_dispatch_unit.sv - in-order issue queue, unit dispatch and RR writeback merge
//
// Purpose: buffers register-read output in a DEPTH-entry in-order queue,
//   issues the head to the functional unit selected by its unit code, drops
//   entries with illegal codes, and merges unit results onto a single
//   registered writeback port with round-robin fairness.
// Optional feature: EXEC_DISPATCH_STATS_EN adds saturating dispatch/stall
//   counters (dispatchCount_o, stallCount_o).
// Ports:
//   clock_i, reset_i                 clock, synchronous active-high reset
//   flush_i                          discard all queued instructions
//   enable_i/ready_o                 instruction handshake from register read
//   unitCode_i, instrAddr_i, payload_i   incoming instruction
//   unitValid_o/unitReady_i          one-hot issue handshake per unit
//   unitAddr_o, unitPayload_o        head instruction, shared by all units
//   illegalUnit_o                    pulse: an illegal-code entry was dropped
//   resultValid_i, resultData_i      per-unit results, unit 0 in LSBs
//   resultAck_o                      one-hot, result consumed this cycle
//   wbValid_o, wbUnit_o, wbData_o    registered writeback
//   dispatchCount_o, stallCount_o    statistics (EXEC_DISPATCH_STATS_EN only)

module exec_dispatch_unit #(
    parameter int NUM_UNITS   = 5,
    parameter int UNIT_CODE_W = exec_pkg::UNIT_CODE_W,
    parameter int DEPTH       = 4,
    parameter int PAYLOAD_W   = 256,
    parameter int RESULT_W    = 72
) (
    input  logic                          clock_i,
    input  logic                          reset_i,
    input  logic                          flush_i,
    input  logic                          enable_i,
    output logic                          ready_o,
    input  logic [UNIT_CODE_W-1:0]        unitCode_i,
    input  logic [63:0]                   instrAddr_i,
    input  logic [PAYLOAD_W-1:0]          payload_i,
    output logic [NUM_UNITS-1:0]          unitValid_o,
    input  logic [NUM_UNITS-1:0]          unitReady_i,
    output logic [63:0]                   unitAddr_o,
    output logic [PAYLOAD_W-1:0]          unitPayload_o,
    output logic                          illegalUnit_o,
    input  logic [NUM_UNITS-1:0]          resultValid_i,
    input  logic [NUM_UNITS*RESULT_W-1:0] resultData_i,
    output logic [NUM_UNITS-1:0]          resultAck_o,
`ifdef EXEC_DISPATCH_STATS_EN
    output logic [31:0]                   dispatchCount_o,
    output logic [31:0]                   stallCount_o,
`endif
    output logic                          wbValid_o,
    output logic [UNIT_CODE_W-1:0]        wbUnit_o,
    output logic [RESULT_W-1:0]           wbData_o
);

    import exec_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // ---------------------------------------------------------------- queue
    logic [UNIT_CODE_W-1:0] mem_code    [DEPTH];
    logic [63:0]            mem_addr    [DEPTH];
    logic [PAYLOAD_W-1:0]   mem_payload [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             illegal_q;

    logic                   push;
    logic                   pop;
    logic                   head_valid;
    logic                   head_legal;
    logic [UNIT_CODE_W-1:0] head_code;
    logic [NUM_UNITS-1:0]   head_onehot;
    logic                   head_unit_ready;
    logic                   issue;
    logic                   illegal_drop;

    // Ready is derived from the registered count only, so a full queue
    // cannot accept even when the head pops this cycle.
    assign ready_o    = !reset_i && (count_q < CNT_W'(DEPTH));
    // Flush wins over a simultaneous push: the input is dropped.
    assign push       = enable_i && ready_o && !flush_i;

    assign head_valid = (count_q != '0) && !flush_i;
    assign head_code  = mem_code[rd_ptr_q];
    assign head_legal = unit_code_legal(int'(head_code), NUM_UNITS);

    always_comb begin
        head_onehot = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            head_onehot[i] = (int'(head_code) == i);
        end
    end

    assign head_unit_ready = |(head_onehot & unitReady_i);
    assign issue           = head_valid && head_legal;
    assign illegal_drop    = head_valid && !head_legal;
    // Illegal entries leave the queue the same cycle they reach the head.
    assign pop             = (issue && head_unit_ready) || illegal_drop;

    assign unitValid_o   = issue ? head_onehot : '0;
    assign unitAddr_o    = mem_addr[rd_ptr_q];
    assign unitPayload_o = mem_payload[rd_ptr_q];
    assign illegalUnit_o = illegal_q;

    always_ff @(posedge clock_i) begin
        if (push) begin
            mem_code[wr_ptr_q]    <= unitCode_i;
            mem_addr[wr_ptr_q]    <= instrAddr_i;
            mem_payload[wr_ptr_q] <= payload_i;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_drop;
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   count_q <= count_q + CNT_W'(1);
                    2'b01:   count_q <= count_q - CNT_W'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // ------------------------------------------------------------ writeback
    logic [NUM_UNITS-1:0]   arb_request;
    logic [NUM_UNITS-1:0]   arb_grant;
    logic [UNIT_CODE_W-1:0] arb_idx;
    logic                   arb_valid;
    logic [RESULT_W-1:0]    result_sel;

    // No grant is issued while in reset, so nothing is acked and lost.
    assign arb_request = reset_i ? '0 : resultValid_i;

    rr_arbiter #(
        .N     (NUM_UNITS),
        .IDX_W (UNIT_CODE_W)
    ) u_wb_arbiter (
        .clk         (clock_i),
        .rst         (reset_i),
        .request     (arb_request),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    assign resultAck_o = arb_grant;

    always_comb begin
        result_sel = '0;
        for (int j = 0; j < NUM_UNITS; j++) begin
            if (arb_grant[j]) begin
                result_sel = resultData_i[j*RESULT_W +: RESULT_W];
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wbValid_o <= 1'b0;
            wbUnit_o  <= '0;
            wbData_o  <= '0;
        end else begin
            wbValid_o <= arb_valid;
            if (arb_valid) begin
                wbUnit_o <= arb_idx;
                wbData_o <= result_sel;
            end
        end
    end

`ifdef EXEC_DISPATCH_STATS_EN
    // ----------------------------------------------------------- statistics
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            dispatchCount_o <= '0;
            stallCount_o    <= '0;
        end else begin
            if (issue && head_unit_ready && (dispatchCount_o != 32'hFFFF_FFFF)) begin
                dispatchCount_o <= dispatchCount_o + 32'd1;
            end
            if (issue && !head_unit_ready && (stallCount_o != 32'hFFFF_FFFF)) begin
                stallCount_o <= stallCount_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_exec_dispatch_unit.sv
// tb/tb_exec_dispatch_unit.sv - directed self-checking bench for exec_dispatch_unit

module tb_exec_dispatch_unit;

    localparam int NU = 5;
    localparam int RW = 72;
    localparam int PW = 256;

    logic           clock_i = 1'b0;
    logic           reset_i;
    logic           flush_i;
    logic           enable_i;
    logic           ready_o;
    logic [2:0]     unitCode_i;
    logic [63:0]    instrAddr_i;
    logic [PW-1:0]  payload_i;
    logic [NU-1:0]  unitValid_o;
    logic [NU-1:0]  unitReady_i;
    logic [63:0]    unitAddr_o;
    logic [PW-1:0]  unitPayload_o;
    logic           illegalUnit_o;
    logic [NU-1:0]  resultValid_i;
    logic [NU*RW-1:0] resultData_i;
    logic [NU-1:0]  resultAck_o;
    logic           wbValid_o;
    logic [2:0]     wbUnit_o;
    logic [RW-1:0]  wbData_o;
`ifdef EXEC_DISPATCH_STATS_EN
    logic [31:0]    dispatchCount_o;
    logic [31:0]    stallCount_o;
`endif

    int checks   = 0;
    int failures = 0;

    exec_dispatch_unit dut (
        .clock_i       (clock_i),
        .reset_i       (reset_i),
        .flush_i       (flush_i),
        .enable_i      (enable_i),
        .ready_o       (ready_o),
        .unitCode_i    (unitCode_i),
        .instrAddr_i   (instrAddr_i),
        .payload_i     (payload_i),
        .unitValid_o   (unitValid_o),
        .unitReady_i   (unitReady_i),
        .unitAddr_o    (unitAddr_o),
        .unitPayload_o (unitPayload_o),
        .illegalUnit_o (illegalUnit_o),
        .resultValid_i (resultValid_i),
        .resultData_i  (resultData_i),
        .resultAck_o   (resultAck_o),
`ifdef EXEC_DISPATCH_STATS_EN
        .dispatchCount_o (dispatchCount_o),
        .stallCount_o    (stallCount_o),
`endif
        .wbValid_o     (wbValid_o),
        .wbUnit_o      (wbUnit_o),
        .wbData_o      (wbData_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic cyc();
        @(posedge clock_i);
        #1;
    endtask

    initial begin
        reset_i       = 1'b1;
        flush_i       = 1'b0;
        enable_i      = 1'b0;
        unitCode_i    = '0;
        instrAddr_i   = '0;
        payload_i     = '0;
        unitReady_i   = '0;
        resultValid_i = '0;
        resultData_i  = '0;

        // ---------------- reset
        cyc();
        #1;
        check("rst_ready_low", ready_o, 0);
        cyc();
        reset_i = 1'b0;
        #1;
        check("rst_ready_high", ready_o, 1);
        check("rst_unit_valid", unitValid_o, 0);
        check("rst_result_ack", resultAck_o, 0);
        check("rst_wb_valid", wbValid_o, 0);
        check("rst_wb_unit", wbUnit_o, 0);
        check("rst_wb_data", wbData_o, 0);
        check("rst_illegal", illegalUnit_o, 0);
        cyc();

        // ---------------- 4 FX back to back, units always ready
        unitReady_i = 5'b11111;
        for (int i = 0; i < 6; i++) begin
            enable_i    = (i < 4);
            unitCode_i  = 3'd0;
            instrAddr_i = 64'h100 + 64'(i);
            payload_i   = 256'hA0 + 256'(i);
            #1;
            check("t1_ready", ready_o, 1);
            check("t1_valid", unitValid_o, (i > 0 && i < 5) ? 5'b00001 : 5'b00000);
            if (i > 0 && i < 5) check("t1_addr", unitAddr_o, 64'h100 + 64'(i - 1));
            cyc();
        end

        // ---------------- fill with units stalled, 5th push held off
        unitReady_i = 5'b00000;
        enable_i    = 1'b1;
        for (int j = 0; j < 5; j++) begin
            instrAddr_i = 64'h200 + 64'(j);
            payload_i   = 256'hB0 + 256'(j);
            #1;
            check("t2_ready", ready_o, (j < 4) ? 1 : 0);
            if (j > 0) begin
                check("t2_stall_valid", unitValid_o, 5'b00001);
                check("t2_stall_addr", unitAddr_o, 64'h200);
            end
            cyc();
        end
        enable_i    = 1'b0;
        unitReady_i = 5'b11111;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("t2_drain_valid", unitValid_o, (k < 4) ? 5'b00001 : 5'b00000);
            if (k < 4) check("t2_drain_addr", unitAddr_o, 64'h200 + 64'(k));
            if (k == 0) check("t2_payload", unitPayload_o, 256'hB0);
            check("t2_drain_ready", ready_o, (k > 0) ? 1 : 0);
            cyc();
        end

        // ---------------- illegal code 7 at head
        enable_i    = 1'b1;
        unitCode_i  = 3'd7;
        instrAddr_i = 64'h300;
        #1;
        check("t3_c0_valid", unitValid_o, 0);
        cyc();
        unitCode_i  = 3'd0;
        instrAddr_i = 64'h301;
        #1;
        check("t3_c1_valid", unitValid_o, 0);
        check("t3_c1_illegal", illegalUnit_o, 0);
        cyc();
        enable_i = 1'b0;
        #1;
        check("t3_c2_valid", unitValid_o, 5'b00001);
        check("t3_c2_addr", unitAddr_o, 64'h301);
        check("t3_c2_illegal", illegalUnit_o, 1);
        cyc();
        #1;
        check("t3_c3_valid", unitValid_o, 0);
        check("t3_c3_illegal", illegalUnit_o, 0);
        cyc();

        // ---------------- in-order: FP head blocks FX behind it
        unitReady_i = 5'b00001;
        enable_i    = 1'b1;
        unitCode_i  = 3'd1;
        instrAddr_i = 64'h400;
        #1;
        cyc();
        unitCode_i  = 3'd0;
        instrAddr_i = 64'h401;
        #1;
        check("t4_c1_valid", unitValid_o, 5'b00010);
        cyc();
        enable_i = 1'b0;
        #1;
        check("t4_c2_valid", unitValid_o, 5'b00010);
        check("t4_c2_addr", unitAddr_o, 64'h400);
        cyc();
        unitReady_i = 5'b00011;
        #1;
        check("t4_c3_valid", unitValid_o, 5'b00010);
        check("t4_c3_addr", unitAddr_o, 64'h400);
        cyc();
        #1;
        check("t4_c4_valid", unitValid_o, 5'b00001);
        check("t4_c4_addr", unitAddr_o, 64'h401);
        cyc();
        #1;
        check("t4_c5_valid", unitValid_o, 0);
        check("t4_wb_idle", wbValid_o, 0);
        cyc();

        // ---------------- writeback round robin, all units pending
        for (int u = 0; u < NU; u++) resultData_i[u*RW +: RW] = 72'hD00 + 72'(u);
        resultValid_i = 5'b11111;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("t5_ack", resultAck_o, 5'b00001 << k);
            check("t5_wb_valid", wbValid_o, (k > 0) ? 1 : 0);
            if (k > 0) begin
                check("t5_wb_unit", wbUnit_o, 3'(k - 1));
                check("t5_wb_data", wbData_o, 72'hD00 + 72'(k - 1));
            end
            cyc();
        end
        resultValid_i = 5'b00000;
        #1;
        check("t5_ack_idle", resultAck_o, 0);
        check("t5_wb_last_valid", wbValid_o, 1);
        check("t5_wb_last_unit", wbUnit_o, 3'd4);
        check("t5_wb_last_data", wbData_o, 72'hD04);
        cyc();
        #1;
        check("t5_wb_drop", wbValid_o, 0);
        // pointer wrapped to 0; grant 2 moves it to 3
        resultValid_i = 5'b00100;
        #1;
        check("t5_ack_u2", resultAck_o, 5'b00100);
        cyc();
        // pointer 3, requests 0 and 1 -> wrap to 0
        resultValid_i = 5'b00011;
        #1;
        check("t5_ack_wrap", resultAck_o, 5'b00001);
        cyc();
        #1;
        check("t5_wb_u2_after", wbUnit_o, 3'd0);
        check("t5_ack_next", resultAck_o, 5'b00010);
        cyc();
        resultValid_i = 5'b00000;
        #1;
        check("t5_wb_u1", wbUnit_o, 3'd1);
        cyc();

        // ---------------- flush with 3 queued plus a simultaneous push
        unitReady_i = 5'b00000;
        enable_i    = 1'b1;
        unitCode_i  = 3'd0;
        for (int j = 0; j < 3; j++) begin
            instrAddr_i = 64'h500 + 64'(j);
            #1;
            cyc();
        end
        instrAddr_i = 64'h503;
        flush_i     = 1'b1;
        #1;
        check("t6_flush_ready", ready_o, 1);
        cyc();
        flush_i     = 1'b0;
        enable_i    = 1'b0;
        unitReady_i = 5'b11111;
        #1;
        check("t6_after_valid", unitValid_o, 0);
        check("t6_after_ready", ready_o, 1);
        cyc();
        #1;
        check("t6_after2_valid", unitValid_o, 0);
        enable_i    = 1'b1;
        instrAddr_i = 64'h600;
        cyc();
        enable_i = 1'b0;
        #1;
        check("t6_post_valid", unitValid_o, 5'b00001);
        check("t6_post_addr", unitAddr_o, 64'h600);
        cyc();

        // ---------------- reset mid-operation
        unitReady_i = 5'b00000;
        enable_i    = 1'b1;
        instrAddr_i = 64'h700;
        #1;
        cyc();
        enable_i      = 1'b0;
        reset_i       = 1'b1;
        resultValid_i = 5'b00001;
        #1;
        check("t7_rst_ready", ready_o, 0);
        check("t7_rst_ack", resultAck_o, 0);
        cyc();
        reset_i       = 1'b0;
        resultValid_i = 5'b00000;
        unitReady_i   = 5'b11111;
        #1;
        check("t7_post_valid", unitValid_o, 0);
        check("t7_post_ready", ready_o, 1);
        check("t7_post_wb", wbValid_o, 0);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
